// File: rtl/px_osc_array_ctrl.sv
// Pixel-oscillator array: NUM_PX independent clk_px channels derived from clk_i.
// Each channel runs IDLE/RUN/DRAIN; stops always park clk_px low after a full phase.
module px_osc_array_ctrl #(
  parameter int unsigned NUM_PX   = 16,
  parameter int unsigned IDX_W    = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned DEF_HALF = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cfg_valid_i,
  input  logic [IDX_W-1:0]  cfg_idx_i,
  input  logic [CNT_W-1:0]  cfg_half_i,
  input  logic [IDX_W:0]    start_osc_i,
  input  logic [IDX_W:0]    stop_osc_i,
  input  logic              stop_all_i,
  output logic [NUM_PX-1:0] clk_px_o,
  output logic [NUM_PX-1:0] running_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  for (genvar i = 0; i < NUM_PX; i++) begin : gen_ch
    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] half_act_q, half_act_d;
    logic [CNT_W-1:0] half_sh_q, half_sh_d;
    logic [CNT_W-1:0] h_m1;
    logic             clk_q, clk_d;
    logic             start_hit, stop_hit, cfg_hit, tog;

    // Out-of-range indices never match any channel, so they are ignored for free.
    assign start_hit = start_osc_i[IDX_W] && (start_osc_i[IDX_W-1:0] == IDX_W'(i));
    assign stop_hit  = (stop_osc_i[IDX_W] && (stop_osc_i[IDX_W-1:0] == IDX_W'(i))) ||
                       stop_all_i;
    assign cfg_hit   = cfg_valid_i && (cfg_idx_i == IDX_W'(i));

    // A half-period of 0 behaves as 1.
    assign h_m1 = (half_act_q == '0) ? '0 : half_act_q - CNT_W'(1);
    assign tog  = (cnt_q == h_m1);

    // Next-state: phase counter, toggle, stop/drain handling and shadow config.
    always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      clk_d      = clk_q;
      half_act_d = half_act_q;
      half_sh_d  = cfg_hit ? cfg_half_i : half_sh_q;
      unique case (state_q)
        StIdle: begin
          cnt_d      = '0;
          clk_d      = 1'b0;
          half_act_d = half_sh_q;
          if (start_hit && !stop_hit) state_d = StRun;
        end
        StRun: begin
          cnt_d = tog ? '0 : cnt_q + CNT_W'(1);
          if (tog) begin
            clk_d      = ~clk_q;
            half_act_d = half_sh_q;
          end
          if (stop_hit) begin
            // Low phase, or high phase ending right now: park immediately, no new rise.
            if (!clk_q || tog) begin
              state_d = StIdle;
              cnt_d   = '0;
              clk_d   = 1'b0;
            end else begin
              state_d = StDrain;
            end
          end
        end
        StDrain: begin
          cnt_d = tog ? '0 : cnt_q + CNT_W'(1);
          if (tog) begin
            clk_d      = 1'b0;
            half_act_d = half_sh_q;
          end
          // Stop beats a coincident start (e.g. stop_all with start).
          if (start_hit && !stop_hit) begin
            state_d = StRun;
          end else if (tog) begin
            state_d = StIdle;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          clk_d   = 1'b0;
        end
      endcase
    end

    // State register with synchronous reset restoring the default half-period.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        state_q    <= StIdle;
        cnt_q      <= '0;
        clk_q      <= 1'b0;
        half_act_q <= CNT_W'(DEF_HALF);
        half_sh_q  <= CNT_W'(DEF_HALF);
      end else begin
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        clk_q      <= clk_d;
        half_act_q <= half_act_d;
        half_sh_q  <= half_sh_d;
      end
    end

    assign clk_px_o[i]  = clk_q;
    assign running_o[i] = (state_q != StIdle);
  end

endmodule

// File: tb/tb_px_osc_array_ctrl.sv
// Directed bench for px_osc_array_ctrl with an expected-output scoreboard queue.
module tb_px_osc_array_ctrl;
  localparam int NP = 12;
  localparam int IW = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic [IW-1:0] cfg_idx = '0;
  logic [CW-1:0] cfg_half = '0;
  logic [IW:0]   start_osc = '0;
  logic [IW:0]   stop_osc = '0;
  logic          stop_all = 1'b0;
  logic [NP-1:0] clk_px;
  logic [NP-1:0] running;

  typedef struct {
    string         tag;
    logic [NP-1:0] clk;
    logic [NP-1:0] run;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  px_osc_array_ctrl #(
    .NUM_PX  (NP),
    .IDX_W   (IW),
    .CNT_W   (CW),
    .DEF_HALF(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .cfg_valid_i(cfg_valid),
    .cfg_idx_i  (cfg_idx),
    .cfg_half_i (cfg_half),
    .start_osc_i(start_osc),
    .stop_osc_i (stop_osc),
    .stop_all_i (stop_all),
    .clk_px_o   (clk_px),
    .running_o  (running)
  );

  always #5 clk = ~clk;

  function automatic logic [NP-1:0] bv(int ch, bit v);
    logic [NP-1:0] r;
    r = '0;
    r[ch] = v;
    return r;
  endfunction

  // Square wave of half-period h, observation k counted from the first RUN cycle.
  function automatic bit sq(int k, int h);
    return ((k / h) % 2) == 1;
  endfunction

  task automatic push(string tag, logic [NP-1:0] c, logic [NP-1:0] r);
    exp_t e;
    e.tag = tag;
    e.clk = c;
    e.run = r;
    sb.push_back(e);
  endtask

  task automatic start(int ch);
    start_osc = {1'b1, IW'(ch)};
  endtask

  // Advance n cycles; strobes last one edge; outputs sampled 1 time unit after the edge.
  task automatic run_cycles(int n);
    exp_t e;
    for (int j = 0; j < n; j++) begin
      @(posedge clk);
      #1;
      rst       = 1'b0;
      cfg_valid = 1'b0;
      start_osc = '0;
      stop_osc  = '0;
      stop_all  = 1'b0;
      n_chk++;
      assert (sb.size() > 0) n_pass++;
      else $error("FAIL sb_empty: got queue size %0d want >0", sb.size());
      if (sb.size() > 0) begin
        e = sb.pop_front();
        n_chk++;
        assert (clk_px === e.clk) n_pass++;
        else $error("FAIL %s clk_px: got %h want %h", e.tag, clk_px, e.clk);
        n_chk++;
        assert (running === e.run) n_pass++;
        else $error("FAIL %s running: got %h want %h", e.tag, running, e.run);
      end
    end
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    push(tag, '0, '0);
    run_cycles(1);
  endtask

  initial begin
    // T1: ch3 at default H=4; rise 4 observations after the start edge, period 8.
    do_reset("reset");
    start(3);
    for (int k = 0; k < 20; k++) push("ch3_run", bv(3, sq(k, 4)), bv(3, 1'b1));
    run_cycles(20);
    // Stop during the low phase just before a rise: parks at once, no rise.
    stop_osc = {1'b1, IW'(3)};
    push("ch3_stop_low", '0, '0);
    push("ch3_idle", '0, '0);
    run_cycles(2);

    // T2: half=0 treated as 1 on ch0 -> toggles every cycle.
    do_reset("reset2");
    cfg_valid = 1'b1;
    cfg_idx   = IW'(0);
    cfg_half  = 8'd0;
    push("cfg0_idle", '0, '0);
    push("cfg0_idle2", '0, '0);
    run_cycles(2);
    start(0);
    for (int k = 0; k < 8; k++) push("ch0_h1", bv(0, sq(k, 1)), bv(0, 1'b1));
    run_cycles(8);
    stop_all = 1'b1;
    push("ch0_stopall", '0, '0);
    run_cycles(1);

    // T3: ch5 stopped mid-high phase drains to a full 4-cycle high, then parks.
    do_reset("reset3");
    start(5);
    for (int k = 0; k < 6; k++) push("ch5_run", bv(5, sq(k, 4)), bv(5, 1'b1));
    run_cycles(6);
    stop_osc = {1'b1, IW'(5)};
    for (int k = 6; k < 11; k++)
      push("ch5_drain", bv(5, k < 8), bv(5, k < 8));
    run_cycles(5);

    // T4: ch2 half rewritten to 6 mid-high; current phase keeps 4, next phase is 6.
    do_reset("reset4");
    start(2);
    for (int k = 0; k < 6; k++) push("ch2_run", bv(2, sq(k, 4)), bv(2, 1'b1));
    run_cycles(6);
    cfg_valid = 1'b1;
    cfg_idx   = IW'(2);
    cfg_half  = 8'd6;
    for (int k = 6; k < 22; k++)
      push("ch2_cfg6", bv(2, (k < 8) || (k >= 14 && k < 20)), bv(2, 1'b1));
    run_cycles(16);

    // T5: ch1 and ch4 running; start ch7 together with stop_all -> ch7 stays idle.
    do_reset("reset5");
    start(1);
    push("ch1_start", '0, bv(1, 1'b1));
    run_cycles(1);
    start(4);
    for (int k = 1; k < 6; k++)
      push("ch1_ch4_run", bv(1, sq(k, 4)) | bv(4, sq(k - 1, 4)), bv(1, 1'b1) | bv(4, 1'b1));
    run_cycles(5);
    stop_all = 1'b1;
    start(7);
    for (int k = 6; k < 12; k++)
      push("stopall_drain", bv(1, k < 8) | bv(4, k < 9), bv(1, k < 8) | bv(4, k < 9));
    run_cycles(6);

    // T6: reset mid-run with ch6 and ch9 high, then H restored to 4 on ch6.
    do_reset("reset6");
    cfg_valid = 1'b1;
    cfg_idx   = IW'(6);
    cfg_half  = 8'd2;
    push("cfg6_idle", '0, '0);
    push("cfg6_idle2", '0, '0);
    run_cycles(2);
    start(6);
    push("ch6_start", '0, bv(6, 1'b1));
    run_cycles(1);
    start(9);
    for (int k = 1; k < 7; k++)
      push("ch6_ch9_run", bv(6, sq(k, 2)) | bv(9, sq(k - 1, 4)), bv(6, 1'b1) | bv(9, 1'b1));
    run_cycles(6);
    rst = 1'b1;
    push("reset_midrun", '0, '0);
    run_cycles(1);
    start(6);
    for (int k = 0; k < 10; k++) push("ch6_def_half", bv(6, sq(k, 4)), bv(6, 1'b1));
    run_cycles(10);

    // T7: out-of-range start and config are ignored.
    do_reset("reset7");
    start(13);
    cfg_valid = 1'b1;
    cfg_idx   = IW'(14);
    cfg_half  = 8'd1;
    for (int k = 0; k < 3; k++) push("oor_start", '0, '0);
    run_cycles(3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
